// File: rtl/score_pkg.sv
`default_nettype none
// ============================================================================
// Module      : score_pkg
// Description : Shared codes, state encodings and score arithmetic helpers
//               for the score_keeper judgement-to-score stage.
// Revision    : 1.0 - initial release
// ============================================================================
package score_pkg;

    // Judgement codes from the note-judge logic
    localparam logic [1:0] JUDGE_NONE    = 2'b00;
    localparam logic [1:0] JUDGE_PERFECT = 2'b01;
    localparam logic [1:0] JUDGE_GOOD    = 2'b10;
    localparam logic [1:0] JUDGE_MISS    = 2'b11;

    // Sound command codes towards the display/sound block
    localparam logic [1:0] SND_SILENT    = 2'b00;
    localparam logic [1:0] SND_PERFECT   = 2'b01;
    localparam logic [1:0] SND_GOOD      = 2'b10;
    localparam logic [1:0] SND_MISS      = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [15:0] SCORE_MAX = 16'd9999;
    localparam logic [7:0]  COMBO_MAX = 8'd99;

    // Operands never exceed 9999 + 509, so the 16-bit sum cannot wrap
    function automatic logic [15:0] sat_score_add(input logic [15:0] a,
                                                  input logic [15:0] b);
        logic [15:0] sum;
        sum = a + b;
        return (sum > SCORE_MAX) ? SCORE_MAX : sum;
    endfunction

    function automatic logic [1:0] judge_to_snd(input logic [1:0] judge);
        logic [1:0] snd;
        snd = SND_SILENT;
        case (judge)
            JUDGE_PERFECT: snd = SND_PERFECT;
            JUDGE_GOOD:    snd = SND_GOOD;
            JUDGE_MISS:    snd = SND_MISS;
            default:       snd = SND_SILENT;
        endcase
        return snd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sound_cmd_timer.sv
`default_nettype none
// ============================================================================
// Module      : sound_cmd_timer
// Description : Holds a sound command code for SOUND_HOLD cycles after each
//               load; a new load overrides the code and restarts the hold.
// Revision    : 1.0 - initial release
// ============================================================================
module sound_cmd_timer
    import score_pkg::*;
#(
    parameter int SOUND_HOLD = 5_000_000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_Clear,
    input  logic       i_Load,
    input  logic [1:0] i_Code,
    output logic [1:0] o_Sound_Cmd
);

    localparam int                 c_TMR_W    = (SOUND_HOLD > 1) ? $clog2(SOUND_HOLD) : 1;
    localparam logic [c_TMR_W-1:0] c_TMR_LOAD = c_TMR_W'(SOUND_HOLD - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE  = c_TMR_W'(1);

    logic [c_TMR_W-1:0] r_timer;
    logic [1:0]         r_cmd;

    // Code drops to silent on the cycle after the timer has counted down to 0
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_timer <= '0;
            r_cmd   <= SND_SILENT;
        end else if (i_Clear) begin
            r_timer <= '0;
            r_cmd   <= SND_SILENT;
        end else if (i_Load) begin
            r_timer <= c_TMR_LOAD;
            r_cmd   <= i_Code;
        end else if (r_cmd != SND_SILENT) begin
            if (r_timer == '0) begin
                r_cmd <= SND_SILENT;
            end else begin
                r_timer <= r_timer - c_TMR_ONE;
            end
        end
    end

    assign o_Sound_Cmd = r_cmd;

endmodule
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
// Module      : score_keeper
// Description : Converts judgement pulses into a saturating score, combo,
//               max combo and held sound command. Define
//               SCORE_KEEPER_FULLCOMBO_EN to add the full-combo bonus/flag.
// Revision    : 1.0 - initial release
// ============================================================================
module score_keeper
    import score_pkg::*;
#(
    parameter int PTS_PERFECT = 10,
    parameter int PTS_GOOD    = 5,
    parameter int SOUND_HOLD  = 5_000_000
`ifdef SCORE_KEEPER_FULLCOMBO_EN
    ,
    parameter int FC_BONUS    = 500
`endif
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_Start,
    input  logic        i_End,
    input  logic        i_Judge_Valid,
    input  logic [1:0]  i_Judge,
    output logic [15:0] o_Score,
    output logic [7:0]  o_Combo,
    output logic [7:0]  o_Max_Combo,
    output logic [1:0]  o_Sound_Cmd,
    output logic [1:0]  o_State
`ifdef SCORE_KEEPER_FULLCOMBO_EN
    ,
    output logic        o_Full_Combo
`endif
);

    localparam logic [15:0] c_PTS_PERFECT = 16'(PTS_PERFECT);
    localparam logic [15:0] c_PTS_GOOD    = 16'(PTS_GOOD);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_score, w_score_nxt;
    logic [7:0]  r_combo, w_combo_nxt;
    logic [7:0]  r_max_combo, w_max_nxt;

    logic        w_accept;
    logic        w_hit;
    logic        w_miss;
    logic        w_end_now;
    logic [15:0] w_add;
    logic [7:0]  w_combo_inc;

`ifdef SCORE_KEEPER_FULLCOMBO_EN
    localparam logic [15:0] c_FC_BONUS = 16'(FC_BONUS);
    logic r_miss_flag, w_miss_flag_nxt;
    logic r_full_combo, w_full_combo_nxt;
`endif

    // A start pulse takes priority and drops any judgement in the same cycle
    assign w_accept  = (r_state == ST_PLAY) && i_Judge_Valid &&
                       (i_Judge != JUDGE_NONE) && !i_Start;
    assign w_hit     = w_accept && ((i_Judge == JUDGE_PERFECT) || (i_Judge == JUDGE_GOOD));
    assign w_miss    = w_accept && (i_Judge == JUDGE_MISS);
    assign w_end_now = (r_state == ST_PLAY) && i_End && !i_Start;

    assign w_add       = ((i_Judge == JUDGE_PERFECT) ? c_PTS_PERFECT : c_PTS_GOOD) +
                         {8'd0, r_combo / 8'd10};
    assign w_combo_inc = (r_combo >= COMBO_MAX) ? COMBO_MAX : (r_combo + 8'd1);

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state     <= ST_IDLE;
            r_score     <= '0;
            r_combo     <= '0;
            r_max_combo <= '0;
`ifdef SCORE_KEEPER_FULLCOMBO_EN
            r_miss_flag  <= 1'b0;
            r_full_combo <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_score     <= w_score_nxt;
            r_combo     <= w_combo_nxt;
            r_max_combo <= w_max_nxt;
`ifdef SCORE_KEEPER_FULLCOMBO_EN
            r_miss_flag  <= w_miss_flag_nxt;
            r_full_combo <= w_full_combo_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_score_nxt = r_score;
        w_combo_nxt = r_combo;
        w_max_nxt   = r_max_combo;
`ifdef SCORE_KEEPER_FULLCOMBO_EN
        w_miss_flag_nxt  = r_miss_flag;
        w_full_combo_nxt = r_full_combo;
`endif
        if (i_Start) begin
            w_state_nxt = ST_PLAY;
            w_score_nxt = '0;
            w_combo_nxt = '0;
            w_max_nxt   = '0;
`ifdef SCORE_KEEPER_FULLCOMBO_EN
            w_miss_flag_nxt  = 1'b0;
            w_full_combo_nxt = 1'b0;
`endif
        end else begin
            if (w_hit) begin
                w_score_nxt = sat_score_add(r_score, w_add);
                w_combo_nxt = w_combo_inc;
                if (w_combo_inc > r_max_combo) begin
                    w_max_nxt = w_combo_inc;
                end
            end else if (w_miss) begin
                w_combo_nxt = '0;
            end

            case (r_state)
                ST_IDLE: w_state_nxt = ST_IDLE;
                ST_PLAY: if (i_End) w_state_nxt = ST_DONE;
                ST_DONE: w_state_nxt = ST_DONE;
                default: w_state_nxt = ST_IDLE;
            endcase

`ifdef SCORE_KEEPER_FULLCOMBO_EN
            if (w_miss) begin
                w_miss_flag_nxt = 1'b1;
            end
            // Bonus is applied on top of any same-cycle judgement
            if (w_end_now && !r_miss_flag && !w_miss && (w_max_nxt != 8'd0)) begin
                w_score_nxt      = sat_score_add(w_score_nxt, c_FC_BONUS);
                w_full_combo_nxt = 1'b1;
            end
`endif
        end
    end

    sound_cmd_timer #(
        .SOUND_HOLD (SOUND_HOLD)
    ) u_sound_cmd_timer (
        .i_Clk       (i_Clk),
        .i_Rst_n     (i_Rst_n),
        .i_Clear     (i_Start),
        .i_Load      (w_accept),
        .i_Code      (judge_to_snd(i_Judge)),
        .o_Sound_Cmd (o_Sound_Cmd)
    );

    assign o_Score     = r_score;
    assign o_Combo     = r_combo;
    assign o_Max_Combo = r_max_combo;
    assign o_State     = r_state;
`ifdef SCORE_KEEPER_FULLCOMBO_EN
    assign o_Full_Combo = r_full_combo;
`endif

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_keeper
// Description : Directed self-checking bench for score_keeper (SOUND_HOLD=4).
//               Full-combo scenarios build when SCORE_KEEPER_FULLCOMBO_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_keeper;

    localparam int c_SOUND_HOLD = 4;

    logic        i_Clk         = 1'b0;
    logic        i_Rst_n       = 1'b1;
    logic        i_Start       = 1'b0;
    logic        i_End         = 1'b0;
    logic        i_Judge_Valid = 1'b0;
    logic [1:0]  i_Judge       = 2'b00;
    logic [15:0] o_Score;
    logic [7:0]  o_Combo;
    logic [7:0]  o_Max_Combo;
    logic [1:0]  o_Sound_Cmd;
    logic [1:0]  o_State;
`ifdef SCORE_KEEPER_FULLCOMBO_EN
    logic        o_Full_Combo;
`endif

    int errors = 0;
    int checks = 0;

    score_keeper #(
        .PTS_PERFECT (10),
        .PTS_GOOD    (5),
        .SOUND_HOLD  (c_SOUND_HOLD)
`ifdef SCORE_KEEPER_FULLCOMBO_EN
        ,
        .FC_BONUS    (500)
`endif
    ) u_dut (
        .i_Clk         (i_Clk),
        .i_Rst_n       (i_Rst_n),
        .i_Start       (i_Start),
        .i_End         (i_End),
        .i_Judge_Valid (i_Judge_Valid),
        .i_Judge       (i_Judge),
        .o_Score       (o_Score),
        .o_Combo       (o_Combo),
        .o_Max_Combo   (o_Max_Combo),
        .o_Sound_Cmd   (o_Sound_Cmd),
        .o_State       (o_State)
`ifdef SCORE_KEEPER_FULLCOMBO_EN
        ,
        .o_Full_Combo  (o_Full_Combo)
`endif
    );

    always #5 i_Clk = ~i_Clk;

    // Inputs change and outputs are sampled 1 ns after each rising edge
    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic judge(input logic [1:0] j);
        i_Judge_Valid = 1'b1;
        i_Judge       = j;
        tick();
        i_Judge_Valid = 1'b0;
        i_Judge       = 2'b00;
    endtask

    task automatic start_song();
        i_Start = 1'b1;
        tick();
        i_Start = 1'b0;
    endtask

    task automatic end_song();
        i_End = 1'b1;
        tick();
        i_End = 1'b0;
    endtask

    task automatic test_reset();
        #1 i_Rst_n = 1'b0;
        #1;
        checks++;
        if ({o_Score, o_Combo, o_Max_Combo, o_Sound_Cmd, o_State} !== 36'd0) begin
            errors++;
            $display("FAIL reset_init: score=%0d combo=%0d max=%0d snd=%0d state=%0d, want all 0",
                     o_Score, o_Combo, o_Max_Combo, o_Sound_Cmd, o_State);
        end
        tick();
        i_Rst_n = 1'b1;
        tick();
        judge(2'b01);
        checks++;
        if ({o_Score, o_Sound_Cmd, o_State} !== {16'd0, 2'b00, 2'b00}) begin
            errors++;
            $display("FAIL idle_ignore: score=%0d snd=%0d state=%0d, want 0 0 0",
                     o_Score, o_Sound_Cmd, o_State);
        end
        // 8 Perfect (80) + Good (85, combo 9) + Miss + 7 Good (120, combo 7)
        start_song();
        repeat (8) judge(2'b01);
        judge(2'b10);
        judge(2'b11);
        repeat (7) judge(2'b10);
        checks++;
        if ({o_Score, o_Combo, o_Max_Combo, o_Sound_Cmd, o_State} !==
            {16'd120, 8'd7, 8'd9, 2'b10, 2'b01}) begin
            errors++;
            $display("FAIL preload_120: score=%0d combo=%0d max=%0d snd=%0d state=%0d, want 120 7 9 2 1",
                     o_Score, o_Combo, o_Max_Combo, o_Sound_Cmd, o_State);
        end
        #2 i_Rst_n = 1'b0;
        #1;
        checks++;
        if ({o_Score, o_Combo, o_Max_Combo, o_Sound_Cmd, o_State} !== 36'd0) begin
            errors++;
            $display("FAIL reset_async: score=%0d combo=%0d max=%0d snd=%0d state=%0d, want all 0",
                     o_Score, o_Combo, o_Max_Combo, o_Sound_Cmd, o_State);
        end
        tick();
        i_Rst_n = 1'b1;
        tick();
    endtask

    task automatic test_perfect_run();
        start_song();
        repeat (12) judge(2'b01);
        checks++;
        if ({o_Score, o_Combo, o_Max_Combo, o_Sound_Cmd} !== {16'd122, 8'd12, 8'd12, 2'b01}) begin
            errors++;
            $display("FAIL perfect12: score=%0d combo=%0d max=%0d snd=%0d, want 122 12 12 1",
                     o_Score, o_Combo, o_Max_Combo, o_Sound_Cmd);
        end
        for (int k = 2; k <= c_SOUND_HOLD; k++) begin
            tick();
            checks++;
            if (o_Sound_Cmd !== 2'b01) begin
                errors++;
                $display("FAIL hold_cycle%0d: snd=%0d, want 1", k, o_Sound_Cmd);
            end
        end
        tick();
        checks++;
        if (o_Sound_Cmd !== 2'b00) begin
            errors++;
            $display("FAIL hold_release: snd=%0d, want 0", o_Sound_Cmd);
        end
    endtask

    task automatic test_mixed();
        logic [1:0] seq_j   [5] = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b10};
        logic [15:0] exp_sc [5] = '{16'd10, 16'd20, 16'd30, 16'd30, 16'd35};
        logic [7:0]  exp_cb [5] = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1};
        start_song();
        checks++;
        if ({o_Score, o_Combo, o_Max_Combo, o_Sound_Cmd, o_State} !== {36'd0, 2'b01}) begin
            errors++;
            $display("FAIL start_clear: score=%0d combo=%0d max=%0d snd=%0d state=%0d, want 0 0 0 0 1",
                     o_Score, o_Combo, o_Max_Combo, o_Sound_Cmd, o_State);
        end
        for (int i = 0; i < 5; i++) begin
            judge(seq_j[i]);
            checks++;
            if ({o_Score, o_Combo, o_Sound_Cmd} !== {exp_sc[i], exp_cb[i], seq_j[i]}) begin
                errors++;
                $display("FAIL mixed_step%0d: score=%0d combo=%0d snd=%0d, want %0d %0d %0d",
                         i, o_Score, o_Combo, o_Sound_Cmd, exp_sc[i], exp_cb[i], seq_j[i]);
            end
        end
        checks++;
        if (o_Max_Combo !== 8'd3) begin
            errors++;
            $display("FAIL mixed_max: max=%0d, want 3", o_Max_Combo);
        end
        tick();
        tick();
        checks++;
        if (o_Sound_Cmd !== 2'b10) begin
            errors++;
            $display("FAIL good_hold: snd=%0d, want 2", o_Sound_Cmd);
        end
        // Override mid-hold: Perfect at combo 1 adds 10 and restarts a full hold
        judge(2'b01);
        for (int k = 1; k <= c_SOUND_HOLD; k++) begin
            checks++;
            if (o_Sound_Cmd !== 2'b01) begin
                errors++;
                $display("FAIL restart_cycle%0d: snd=%0d, want 1", k, o_Sound_Cmd);
            end
            tick();
        end
        checks++;
        if ({o_Score, o_Sound_Cmd} !== {16'd45, 2'b00}) begin
            errors++;
            $display("FAIL restart_end: score=%0d snd=%0d, want 45 0", o_Score, o_Sound_Cmd);
        end
    endtask

    task automatic test_simultaneous();
        logic [15:0] exp_end;
`ifdef SCORE_KEEPER_FULLCOMBO_EN
        exp_end = 16'd515;
`else
        exp_end = 16'd15;
`endif
        judge(2'b01);
        i_Start = 1'b1; i_Judge_Valid = 1'b1; i_Judge = 2'b01;
        tick();
        i_Start = 1'b0; i_Judge_Valid = 1'b0; i_Judge = 2'b00;
        checks++;
        if ({o_Score, o_Combo, o_Max_Combo, o_Sound_Cmd, o_State} !== {36'd0, 2'b01}) begin
            errors++;
            $display("FAIL start_with_judge: score=%0d combo=%0d max=%0d snd=%0d state=%0d, want 0 0 0 0 1",
                     o_Score, o_Combo, o_Max_Combo, o_Sound_Cmd, o_State);
        end
        judge(2'b01);
        i_End = 1'b1; i_Judge_Valid = 1'b1; i_Judge = 2'b10;
        tick();
        i_End = 1'b0; i_Judge_Valid = 1'b0; i_Judge = 2'b00;
        checks++;
        if ({o_Score, o_Combo, o_Max_Combo, o_Sound_Cmd, o_State} !==
            {exp_end, 8'd2, 8'd2, 2'b10, 2'b10}) begin
            errors++;
            $display("FAIL end_with_good: score=%0d combo=%0d max=%0d snd=%0d state=%0d, want %0d 2 2 2 2",
                     o_Score, o_Combo, o_Max_Combo, o_Sound_Cmd, o_State, exp_end);
        end
`ifdef SCORE_KEEPER_FULLCOMBO_EN
        checks++;
        if (o_Full_Combo !== 1'b1) begin
            errors++;
            $display("FAIL fc_end_with_good: fc=%0d, want 1", o_Full_Combo);
        end
`endif
        judge(2'b01);
        checks++;
        if ({o_Score, o_Combo, o_Sound_Cmd, o_State} !== {exp_end, 8'd2, 2'b10, 2'b10}) begin
            errors++;
            $display("FAIL done_ignore: score=%0d combo=%0d snd=%0d state=%0d, want %0d 2 2 2",
                     o_Score, o_Combo, o_Sound_Cmd, o_State, exp_end);
        end
        i_Start = 1'b1; i_End = 1'b1;
        tick();
        i_Start = 1'b0; i_End = 1'b0;
        checks++;
        if ({o_Score, o_Combo, o_Max_Combo, o_State} !== {32'd0, 2'b01}) begin
            errors++;
            $display("FAIL start_with_end: score=%0d combo=%0d max=%0d state=%0d, want 0 0 0 1",
                     o_Score, o_Combo, o_Max_Combo, o_State);
        end
    endtask

    task automatic test_saturation();
        start_song();
        repeat (99) judge(2'b01);
        checks++;
        if ({o_Score, o_Combo, o_Max_Combo} !== {16'd1431, 8'd99, 8'd99}) begin
            errors++;
            $display("FAIL run99: score=%0d combo=%0d max=%0d, want 1431 99 99",
                     o_Score, o_Combo, o_Max_Combo);
        end
        judge(2'b01);
        checks++;
        if ({o_Score, o_Combo, o_Max_Combo} !== {16'd1450, 8'd99, 8'd99}) begin
            errors++;
            $display("FAIL combo_sat: score=%0d combo=%0d max=%0d, want 1450 99 99",
                     o_Score, o_Combo, o_Max_Combo);
        end
        repeat (449) judge(2'b01);
        checks++;
        if (o_Score !== 16'd9981) begin
            errors++;
            $display("FAIL near_max: score=%0d, want 9981", o_Score);
        end
        judge(2'b01);
        checks++;
        if ({o_Score, o_Combo} !== {16'd9999, 8'd99}) begin
            errors++;
            $display("FAIL score_sat: score=%0d combo=%0d, want 9999 99", o_Score, o_Combo);
        end
        judge(2'b10);
        checks++;
        if ({o_Score, o_Combo} !== {16'd9999, 8'd99}) begin
            errors++;
            $display("FAIL score_sat_hold: score=%0d combo=%0d, want 9999 99", o_Score, o_Combo);
        end
    endtask

`ifdef SCORE_KEEPER_FULLCOMBO_EN
    task automatic test_full_combo();
        start_song();
        repeat (5) judge(2'b01);
        end_song();
        checks++;
        if ({o_Score, o_Full_Combo, o_State} !== {16'd550, 1'b1, 2'b10}) begin
            errors++;
            $display("FAIL fc_clean: score=%0d fc=%0d state=%0d, want 550 1 2",
                     o_Score, o_Full_Combo, o_State);
        end
        start_song();
        checks++;
        if ({o_Score, o_Full_Combo} !== {16'd0, 1'b0}) begin
            errors++;
            $display("FAIL fc_start_clear: score=%0d fc=%0d, want 0 0", o_Score, o_Full_Combo);
        end
        judge(2'b01); judge(2'b01); judge(2'b11); judge(2'b01); judge(2'b01);
        end_song();
        checks++;
        if ({o_Score, o_Full_Combo, o_State} !== {16'd40, 1'b0, 2'b10}) begin
            errors++;
            $display("FAIL fc_with_miss: score=%0d fc=%0d state=%0d, want 40 0 2",
                     o_Score, o_Full_Combo, o_State);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_perfect_run();
        test_mixed();
        test_simultaneous();
        test_saturation();
`ifdef SCORE_KEEPER_FULLCOMBO_EN
        test_full_combo();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
